sc_bkgtimer: RTL and testbench

- Speed timer directly upstream of the background state machine; it produces that machine's T0_InLow input.
- Counts the state machine's upcount strobes and asserts T0 low once the count reaches the current limit.
- Holds T0 low until the state machine performs a shift (shiftselection = 2'b10).
- Every SHIFTS_PER_LEVEL shifts it raises the level and shortens the limit, so the background scrolls faster.

---
 rtl/sc_bkgtimer.sv | 155 +++++++++++++++
 tb/tb_sc_bkgtimer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_bkgtimer.sv
// sc_bkgtimer: background speed timer feeding T0_InLow of the background FSM.
// Counts upcount strobes; drives T0 low once the count reaches the current
// limit, and holds it low until the FSM acknowledges with a shift (2'b10).
// Every SHIFTS_PER_LEVEL acknowledges the level rises and the limit shrinks.
// Ports:
//   SC_BKGTIMER_CLOCK_50           clock, rising edge
//   SC_BKGTIMER_RESET_InLow        synchronous active-low reset
//   SC_BKGTIMER_upcount_InLow      low = count strobe
//   SC_BKGTIMER_clear_InLow        low = restart game timing
//   SC_BKGTIMER_shiftselection_In  2'b10 = shift performed (acknowledge)
//   SC_BKGTIMER_pause_InHigh       high = freeze counting
//   SC_BKGTIMER_T0_OutLow          low = timer expired
//   SC_BKGTIMER_level_Out          current level
//   SC_BKGTIMER_limit_Out          current limit
//   SC_BKGTIMER_count_Out          current strobe count
//   SC_BKGTIMER_levelUp_OutHigh    one-cycle pulse on level increment
module sc_bkgtimer #(
  parameter int unsigned             COUNT_WIDTH      = 24,
  parameter int unsigned             LEVEL_WIDTH      = 3,
  parameter logic [COUNT_WIDTH-1:0]  BASE_LIMIT       = 24'd5000000,
  parameter logic [COUNT_WIDTH-1:0]  LEVEL_STEP       = 24'd500000,
  parameter logic [COUNT_WIDTH-1:0]  MIN_LIMIT        = 24'd1000000,
  parameter int unsigned             SHIFTS_PER_LEVEL = 8
) (
  input  logic                   SC_BKGTIMER_CLOCK_50,
  input  logic                   SC_BKGTIMER_RESET_InLow,
  input  logic                   SC_BKGTIMER_upcount_InLow,
  input  logic                   SC_BKGTIMER_clear_InLow,
  input  logic [1:0]             SC_BKGTIMER_shiftselection_In,
  input  logic                   SC_BKGTIMER_pause_InHigh,
  output logic                   SC_BKGTIMER_T0_OutLow,
  output logic [LEVEL_WIDTH-1:0] SC_BKGTIMER_level_Out,
  output logic [COUNT_WIDTH-1:0] SC_BKGTIMER_limit_Out,
  output logic [COUNT_WIDTH-1:0] SC_BKGTIMER_count_Out,
  output logic                   SC_BKGTIMER_levelUp_OutHigh
);

  localparam int unsigned CW1     = COUNT_WIDTH + 1;
  localparam int unsigned SHIFT_W = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;
  localparam logic [SHIFT_W-1:0]     SHIFT_LAST = SHIFT_W'(SHIFTS_PER_LEVEL - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = {LEVEL_WIDTH{1'b1}};
  localparam logic [1:0]             SHIFT_ACK  = 2'b10;

  typedef enum logic [1:0] {
    ST_COUNT   = 2'b00,
    ST_EXPIRED = 2'b01,
    ST_LEVELUP = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] limit_q, limit_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic                   t0_q, t0_d;
  logic                   level_up_q, level_up_d;

  // Widened arithmetic so the expiry compare and limit decrement see carries.
  logic [CW1-1:0] count_inc;
  logic [CW1-1:0] limit_dec;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    level_d    = level_q;
    shift_d    = shift_q;
    count_inc  = {1'b0, count_q} + CW1'(1);
    limit_dec  = {1'b0, limit_q} - {1'b0, LEVEL_STEP};

    case (state_q)
      ST_COUNT: begin
        if (!SC_BKGTIMER_upcount_InLow && !SC_BKGTIMER_pause_InHigh) begin
          count_d = count_inc[COUNT_WIDTH-1:0];
          if (count_inc >= {1'b0, limit_q}) begin
            state_d = ST_EXPIRED;
          end
        end
      end
      ST_EXPIRED: begin
        if (SC_BKGTIMER_shiftselection_In == SHIFT_ACK) begin
          count_d = '0;
          if (shift_q == SHIFT_LAST) begin
            if (level_q < LEVEL_MAX) begin
              state_d = ST_LEVELUP;
            end else begin
              shift_d = '0;
              state_d = ST_COUNT;
            end
          end else begin
            shift_d = shift_q + SHIFT_W'(1);
            state_d = ST_COUNT;
          end
        end
      end
      ST_LEVELUP: begin
        level_d = level_q + LEVEL_WIDTH'(1);
        shift_d = '0;
        state_d = ST_COUNT;
        // MSB set means the subtraction wrapped below zero.
        if (limit_dec[COUNT_WIDTH] || (limit_dec[COUNT_WIDTH-1:0] < MIN_LIMIT)) begin
          limit_d = MIN_LIMIT;
        end else begin
          limit_d = limit_dec[COUNT_WIDTH-1:0];
        end
      end
      default: begin
        // Unreachable encoding: restart counting but keep progression.
        state_d = ST_COUNT;
        count_d = '0;
        shift_d = '0;
      end
    endcase

    if (!SC_BKGTIMER_clear_InLow) begin
      state_d = ST_COUNT;
      count_d = '0;
      shift_d = '0;
      level_d = '0;
      limit_d = BASE_LIMIT;
    end

    t0_d       = (state_d != ST_EXPIRED);
    level_up_d = (state_d == ST_LEVELUP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge SC_BKGTIMER_CLOCK_50) begin
    if (!SC_BKGTIMER_RESET_InLow) begin
      state_q    <= ST_COUNT;
      count_q    <= '0;
      shift_q    <= '0;
      level_q    <= '0;
      limit_q    <= BASE_LIMIT;
      t0_q       <= 1'b1;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      level_q    <= level_d;
      limit_q    <= limit_d;
      t0_q       <= t0_d;
      level_up_q <= level_up_d;
    end
  end

  assign SC_BKGTIMER_T0_OutLow       = t0_q;
  assign SC_BKGTIMER_level_Out       = level_q;
  assign SC_BKGTIMER_limit_Out       = limit_q;
  assign SC_BKGTIMER_count_Out       = count_q;
  assign SC_BKGTIMER_levelUp_OutHigh = level_up_q;

endmodule

// File: tb/tb_sc_bkgtimer.sv
// Testbench for sc_bkgtimer with small parameters (limits 4/3/2/2).
module tb_sc_bkgtimer;

  localparam int unsigned CW   = 24;
  localparam int unsigned LW   = 2;
  localparam int          BASE = 4;
  localparam int          STEP = 1;
  localparam int          MINL = 2;
  localparam int          SPL  = 2;
  localparam int          LMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n, clr_n, up_n, pause;
  logic [1:0]    sh;
  logic          t0, lu;
  logic [LW-1:0] lvl;
  logic [CW-1:0] lim, cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_count, m_level, m_shifts;
  bit m_exp, m_lu;

  always #5 clk = ~clk;

  sc_bkgtimer #(
    .COUNT_WIDTH(CW), .LEVEL_WIDTH(LW), .BASE_LIMIT(24'd4), .LEVEL_STEP(24'd1),
    .MIN_LIMIT(24'd2), .SHIFTS_PER_LEVEL(SPL)
  ) dut (
    .SC_BKGTIMER_CLOCK_50(clk),
    .SC_BKGTIMER_RESET_InLow(rst_n),
    .SC_BKGTIMER_upcount_InLow(up_n),
    .SC_BKGTIMER_clear_InLow(clr_n),
    .SC_BKGTIMER_shiftselection_In(sh),
    .SC_BKGTIMER_pause_InHigh(pause),
    .SC_BKGTIMER_T0_OutLow(t0),
    .SC_BKGTIMER_level_Out(lvl),
    .SC_BKGTIMER_limit_Out(lim),
    .SC_BKGTIMER_count_Out(cnt),
    .SC_BKGTIMER_levelUp_OutHigh(lu)
  );

  function automatic int lim_of(input int level);
    int v;
    v = BASE - level * STEP;
    return (v < MINL) ? MINL : v;
  endfunction

  // Game-rule model: one call per clock edge.
  task automatic model(input logic r, input logic c, input logic u, input logic p,
                       input logic [1:0] s);
    if (!r || !c) begin
      m_count = 0; m_level = 0; m_shifts = 0; m_exp = 0; m_lu = 0;
    end else if (m_lu) begin
      m_lu = 0; m_level++; m_shifts = 0;
    end else if (m_exp) begin
      if (s == 2'b10) begin
        m_exp = 0;
        m_count = 0;
        m_shifts++;
        if (m_shifts == SPL) begin
          if (m_level < LMAX) m_lu = 1;
          else m_shifts = 0;
        end
      end
    end else if (!u && !p) begin
      m_count++;
      if (m_count >= lim_of(m_level)) m_exp = 1;
    end
  endtask

  // Apply inputs for one edge, advance the model, settle past the edge.
  task automatic step(input logic r, input logic c, input logic u, input logic p,
                      input logic [1:0] s);
    rst_n = r; clr_n = c; up_n = u; pause = p; sh = s;
    @(posedge clk);
    model(r, c, u, p, s);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic strobe();
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic ack();
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  // Enough strobes to reach the current limit from count 0.
  task automatic run_to_expiry();
    int n;
    n = lim_of(m_level) - m_count;
    for (int i = 0; i < n; i++) strobe();
  endtask

  // From reset, climb to level 2 and sit in EXPIRED.
  task automatic reach_level2_expired();
    do_reset();
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < SPL; k++) begin
        run_to_expiry();
        ack();
      end
      idle();
    end
    run_to_expiry();
  endtask

  task automatic test_reset();
    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    checks++;
    if (t0 !== 1'b1 || lvl !== 2'd0 || lim !== 24'd4 || cnt !== 24'd0 || lu !== 1'b0) begin
      errors++;
      $display("FAIL reset: t0=%b lvl=%0d lim=%0d cnt=%0d lu=%b, want 1 0 4 0 0", t0, lvl, lim, cnt, lu);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    checks++;
    if (cnt !== 24'd0 || t0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: cnt=%0d t0=%b, want 0 1", cnt, t0);
    end
  endtask

  task automatic test_expire();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      strobe();
      checks++;
      if (cnt !== 24'(i) || t0 !== 1'(i < 4)) begin
        errors++;
        $display("FAIL count_up[%0d]: cnt=%0d t0=%b, want %0d %b", i, cnt, t0, i, i < 4);
      end
    end
    for (int i = 0; i < 3; i++) strobe();
    checks++;
    if (cnt !== 24'd4) begin
      errors++;
      $display("FAIL expired_hold: cnt=%0d, want 4", cnt);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
      checks++;
      if (t0 !== 1'b0) begin
        errors++;
        $display("FAIL no_ack[%0d]: t0=%b, want 0", i, t0);
      end
    end
    ack();
    checks++;
    if (t0 !== 1'b1 || cnt !== 24'd0 || lu !== 1'b0) begin
      errors++;
      $display("FAIL ack: t0=%b cnt=%0d lu=%b, want 1 0 0", t0, cnt, lu);
    end
  endtask

  task automatic test_levelup();
    run_to_expiry();
    ack();
    checks++;
    if (lu !== 1'b1 || t0 !== 1'b1) begin
      errors++;
      $display("FAIL levelup_pulse: lu=%b t0=%b, want 1 1", lu, t0);
    end
    strobe();
    checks++;
    if (lu !== 1'b0 || lvl !== 2'd1 || lim !== 24'd3 || cnt !== 24'd0) begin
      errors++;
      $display("FAIL levelup_exit: lu=%b lvl=%0d lim=%0d cnt=%0d, want 0 1 3 0", lu, lvl, lim, cnt);
    end
    strobe(); strobe();
    checks++;
    if (t0 !== 1'b1) begin
      errors++;
      $display("FAIL level1_early: t0=%b, want 1", t0);
    end
    strobe();
    checks++;
    if (t0 !== 1'b0 || cnt !== 24'd3) begin
      errors++;
      $display("FAIL level1_expire: t0=%b cnt=%0d, want 0 3", t0, cnt);
    end
  endtask

  task automatic test_floor();
    int want_lim[4] = '{4, 3, 2, 2};
    ack();
    for (int l = 2; l <= 3; l++) begin
      run_to_expiry();
      ack();
      run_to_expiry();
      ack();
      idle();
      checks++;
      if (lvl !== 2'(l) || lim !== 24'(want_lim[l])) begin
        errors++;
        $display("FAIL floor_level%0d: lvl=%0d lim=%0d, want %0d %0d", l, lvl, lim, l, want_lim[l]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      run_to_expiry();
      ack();
      checks++;
      if (lu !== 1'b0 || t0 !== 1'b1) begin
        errors++;
        $display("FAIL max_ack[%0d]: lu=%b t0=%b, want 0 1", k, lu, t0);
      end
      idle();
      checks++;
      if (lu !== 1'b0 || lvl !== 2'd3 || lim !== 24'd2) begin
        errors++;
        $display("FAIL max_hold[%0d]: lu=%b lvl=%0d lim=%0d, want 0 3 2", k, lu, lvl, lim);
      end
    end
  endtask

  task automatic test_clear_priority();
    for (int v = 0; v < 2; v++) begin
      reach_level2_expired();
      checks++;
      if (t0 !== 1'b0 || lvl !== 2'd2 || lim !== 24'd2) begin
        errors++;
        $display("FAIL clr_setup[%0d]: t0=%b lvl=%0d lim=%0d, want 0 2 2", v, t0, lvl, lim);
      end
      step(1'(v == 0), 1'b0, 1'b1, 1'b0, 2'b10);
      checks++;
      if (t0 !== 1'b1 || lvl !== 2'd0 || lim !== 24'd4 || cnt !== 24'd0 || lu !== 1'b0) begin
        errors++;
        $display("FAIL clr_wins[%0d]: t0=%b lvl=%0d lim=%0d cnt=%0d lu=%b, want 1 0 4 0 0",
                 v, t0, lvl, lim, cnt, lu);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    strobe();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    checks++;
    if (cnt !== 24'd1 || t0 !== 1'b1) begin
      errors++;
      $display("FAIL pause_hold: cnt=%0d t0=%b, want 1 1", cnt, t0);
    end
    idle();
    checks++;
    if (cnt !== 24'd1) begin
      errors++;
      $display("FAIL pause_release_idle: cnt=%0d, want 1", cnt);
    end
    strobe();
    checks++;
    if (cnt !== 24'd2) begin
      errors++;
      $display("FAIL pause_resume: cnt=%0d, want 2", cnt);
    end
  endtask

  task automatic test_random();
    logic r, c, u, p;
    logic [1:0] s;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 99) != 0);
      u = ($urandom_range(0, 1) != 0);
      p = ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 9) < 4) ? 2'b10 : 2'($urandom);
      step(r, c, u, p, s);
      checks++;
      if (t0 !== 1'(!m_exp) || lu !== 1'(m_lu) || lvl !== LW'(m_level) ||
          lim !== CW'(lim_of(m_level)) || cnt !== CW'(m_count)) begin
        errors++;
        $display("FAIL random[%0d]: t0=%b lu=%b lvl=%0d lim=%0d cnt=%0d, want %b %b %0d %0d %0d",
                 i, t0, lu, lvl, lim, cnt, !m_exp, m_lu, m_level, lim_of(m_level), m_count);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr_n = 1'b1; up_n = 1'b1; pause = 1'b0; sh = 2'b00;
    test_reset();
    test_expire();
    test_levelup();
    test_floor();
    test_clear_priority();
    test_pause();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
